// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_t;

  localparam axis_t MODE_640X480_H = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam axis_t MODE_640X480_V = '{active: 480, fp: 10, sync: 2,   bp: 33};
  localparam axis_t MODE_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam axis_t MODE_800X600_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned clamp(input int unsigned value, input int unsigned limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active/sync decode and clamped coordinate.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         wrap,
  output logic         in_active,
  output logic         sync_level,
  output logic [W-1:0] coord
);

  localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC - 1;

  logic [W-1:0] cnt;
  logic         last;
  logic         in_sync;

  assign last = (cnt == W'(TOTAL - 1));
  assign wrap = en & last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Decode is purely from the registered count, so en never reaches the level outputs.
  assign in_active  = (cnt < W'(ACTIVE));
  assign in_sync    = (cnt >= W'(SYNC_START)) && (cnt <= W'(SYNC_END));
  assign sync_level = in_sync ? POL : ~POL;
  assign coord      = W'(clamp(32'(cnt), ACTIVE - 1));

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: sync, active video, coordinates, frame strobes and count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = MODE_640X480_H.active,
  parameter int unsigned H_FP     = MODE_640X480_H.fp,
  parameter int unsigned H_SYNC   = MODE_640X480_H.sync,
  parameter int unsigned H_BP     = MODE_640X480_H.bp,
  parameter int unsigned V_ACTIVE = MODE_640X480_V.active,
  parameter int unsigned V_FP     = MODE_640X480_V.fp,
  parameter int unsigned V_SYNC   = MODE_640X480_V.sync,
  parameter int unsigned V_BP     = MODE_640X480_V.bp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10,
  parameter int unsigned FW       = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pix_stb,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_active,
  output logic          o_screenend,
  output logic          o_animate,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [FW-1:0] o_frame
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (XW == 0 || YW == 0 || FW == 0 || H_ACTIVE == 0 || V_ACTIVE == 0 ||
      H_SYNC == 0 || V_SYNC == 0 ||
      (64'(1) << XW) < 64'(H_TOTAL) || (64'(1) << YW) < 64'(V_TOTAL)) begin : g_bad_params
    $error("vga_timing_gen: illegal parameters (zero width or counter too narrow for total)");
  end

  logic          h_wrap;
  logic          h_active;
  logic          v_wrap;
  logic          v_active;
  logic [YW-1:0] v_coord;
  logic [FW-1:0] frame;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(XW)
  ) u_h (
    .clk       (i_clk),
    .rst       (i_rst),
    .en        (i_pix_stb),
    .wrap      (h_wrap),
    .in_active (h_active),
    .sync_level(o_hs),
    .coord     (o_x)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(YW)
  ) u_v (
    .clk       (i_clk),
    .rst       (i_rst),
    .en        (h_wrap),
    .wrap      (v_wrap),
    .in_active (v_active),
    .sync_level(o_vs),
    .coord     (v_coord)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame <= '0;
    end else if (v_wrap) begin
      frame <= frame + 1'b1;
    end
  end

  // Clamped v_coord also reads V_ACTIVE-1 in blanking, so gate with v_active.
  assign o_animate   = h_wrap & v_active & (v_coord == YW'(V_ACTIVE - 1));
  assign o_screenend = v_wrap;
  assign o_active    = h_active & v_active;
  assign o_y         = v_coord;
  assign o_frame     = frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny active-high-sync mode with FW=2.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_a, stb_a, rst_b, stb_b;
  logic       hs_a, vs_a, act_a, se_a, an_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fr_a;
  logic       hs_b, vs_b, act_b, se_b, an_b;
  logic [3:0] x_b;
  logic [2:0] y_b;
  logic [1:0] fr_b;

  int checks = 0;
  int errors = 0;

  vga_timing_gen dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_pix_stb(stb_a),
    .o_hs(hs_a), .o_vs(vs_a), .o_active(act_a), .o_screenend(se_a), .o_animate(an_a),
    .o_x(x_a), .o_y(y_a), .o_frame(fr_a)
  );

  // 14 x 7 raster: h sync at 10..12, v sync on line 5, 98 strobes per frame.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .XW(4), .YW(3), .FW(2)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_pix_stb(stb_b),
    .o_hs(hs_b), .o_vs(vs_b), .o_active(act_b), .o_screenend(se_b), .o_animate(an_b),
    .o_x(x_b), .o_y(y_b), .o_frame(fr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; stb_a = 1'b0; stb_b = 1'b0;
    adv(2);
    chk("a_rst_x", x_a, 0);     chk("a_rst_y", y_a, 0);
    chk("a_rst_act", act_a, 1); chk("a_rst_hs", hs_a, 1);
    chk("a_rst_vs", vs_a, 1);   chk("a_rst_fr", fr_a, 0);
    chk("a_rst_se", se_a, 0);   chk("a_rst_an", an_a, 0);
    chk("b_rst_hs", hs_b, 0);   chk("b_rst_vs", vs_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    adv(1);
    chk("a_idle_x", x_a, 0);

    // Default mode, continuous strobe
    stb_a = 1'b1;
    adv(1);   chk("a_first_x", x_a, 1);
    adv(654); chk("a_h655_hs", hs_a, 1); chk("a_h655_x", x_a, 639); chk("a_h655_act", act_a, 0);
    adv(1);   chk("a_h656_hs", hs_a, 0);
    adv(95);  chk("a_h751_hs", hs_a, 0);
    adv(1);   chk("a_h752_hs", hs_a, 1);
    adv(47);  chk("a_h799_y", y_a, 0); chk("a_h799_se", se_a, 0); chk("a_h799_an", an_a, 0);
    adv(1);   chk("a_line1_x", x_a, 0); chk("a_line1_y", y_a, 1); chk("a_line1_act", act_a, 1);

    // Strobe every 4th clock
    stb_a = 1'b0; adv(3); chk("a_stall_x0", x_a, 0); chk("a_stall_hs", hs_a, 1);
    stb_a = 1'b1; adv(1); chk("a_stb_x1", x_a, 1);
    stb_a = 1'b0; adv(3); chk("a_stall_x1", x_a, 1);
    stb_a = 1'b1; adv(1); chk("a_stb_x2", x_a, 2);

    // Asynchronous reset between edges at (300, 1)
    adv(298); chk("a_pre_rst_x", x_a, 300); chk("a_pre_rst_y", y_a, 1);
    stb_a = 1'b0;
    #3 rst_a = 1'b1;
    #1 chk("a_async_x", x_a, 0); chk("a_async_y", y_a, 0);
    chk("a_async_act", act_a, 1); chk("a_async_fr", fr_a, 0);
    adv(1);
    rst_a = 1'b0;

    // Small mode, active-high syncs
    stb_b = 1'b1;
    adv(10); chk("b_h10_hs", hs_b, 1); chk("b_h10_x", x_b, 7); chk("b_h10_act", act_b, 0);
    adv(2);  chk("b_h12_hs", hs_b, 1);
    adv(1);  chk("b_h13_hs", hs_b, 0); chk("b_h13_y0_an", an_b, 0);
    adv(1);  chk("b_l1_x", x_b, 0); chk("b_l1_y", y_b, 1);
    adv(41); chk("b_l3_an", an_b, 1); chk("b_l3_y", y_b, 3); chk("b_l3_se", se_b, 0);
    adv(1);  chk("b_l4_an", an_b, 0); chk("b_l4_act", act_b, 0);
             chk("b_l4_y", y_b, 3); chk("b_l4_vs", vs_b, 0);
    adv(14); chk("b_l5_vs", vs_b, 1); chk("b_l5_y", y_b, 3);
    adv(13); chk("b_l5_end_vs", vs_b, 1); chk("b_l5_end_se", se_b, 0);
    adv(1);  chk("b_l6_vs", vs_b, 0);
    adv(13); chk("b_last_se", se_b, 1); chk("b_last_fr", fr_b, 0);
    stb_b = 1'b0;
    #1 chk("b_stall_se", se_b, 0); chk("b_stall_x", x_b, 7);
    stb_b = 1'b1;
    #1;
    adv(1);  chk("b_f1_fr", fr_b, 1); chk("b_f1_se", se_b, 0);
             chk("b_f1_y", y_b, 0); chk("b_f1_act", act_b, 1);
    adv(97); chk("b_f1_last_se", se_b, 1); chk("b_f1_last_fr", fr_b, 1);
    adv(1);  chk("b_fr2", fr_b, 2);
    adv(98); chk("b_fr3", fr_b, 3);
    adv(98); chk("b_fr0_wrap", fr_b, 0);
    adv(98); chk("b_fr1_again", fr_b, 1);

    // Mid-frame async reset clears frame count
    adv(5);  chk("b_pre_rst_x", x_b, 5);
    stb_b = 1'b0;
    #3 rst_b = 1'b1;
    #1 chk("b_async_fr", fr_b, 0); chk("b_async_x", x_b, 0); chk("b_async_y", y_b, 0);
    chk("b_async_hs", hs_b, 0);
    adv(1);
    rst_b = 1'b0;
    adv(1);  chk("b_post_rst_hold_x", x_b, 0);
    stb_b = 1'b1;
    adv(1);  chk("b_post_rst_x", x_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
